// File: rtl/mod12_down_timer_pkg.sv
// mod12_down_timer_pkg: shared constants, state type and clamp helper for the mod-12 down timer
package mod12_down_timer_pkg;

    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] MOD12_MAX = 4'd11;
    localparam logic [CNT_W-1:0] RELOAD_RST = 4'd11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Values outside the mod-12 range saturate at the top count
    function automatic logic [CNT_W-1:0] clamp12(input logic [CNT_W-1:0] v);
        return (v > MOD12_MAX) ? MOD12_MAX : v;
    endfunction

endpackage

// File: rtl/mod12_down_core.sv
// mod12_down_core: count register with clamped load, decrement and underflow wrap
module mod12_down_core
    import mod12_down_timer_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    input  logic             i_wrap,
    input  logic [CNT_W-1:0] i_wrap_val,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_dec_val;

    // At zero a decrement either reloads (periodic) or sticks at zero (one-shot)
    always_comb begin
        w_dec_val = (r_count == '0) ? (i_wrap ? clamp12(i_wrap_val) : '0) : r_count - CNT_W'(1);
    end

    // Load has priority over decrement
    always_ff @(posedge clk) begin
        if (rst)
            r_count <= '0;
        else if (i_load)
            r_count <= clamp12(i_load_val);
        else if (i_dec)
            r_count <= w_dec_val;
    end

    assign o_count = r_count;

endmodule

// File: rtl/mod12_down_timer.sv
// mod12_down_timer: mod-12 down timer with one-shot/periodic modes, IDLE/RUN/DONE control
module mod12_down_timer
    import mod12_down_timer_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] data_in,
    input  logic             en,
    input  logic             start,
    input  logic             mode,
    output logic [CNT_W-1:0] count,
    output logic             borrow,
    output logic             busy,
    output logic             done
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_reload;
    logic             r_borrow;
    logic             w_run;
    logic             w_underflow;
    logic             w_core_load;
    logic [CNT_W-1:0] w_core_val;

    assign w_run       = (r_state == RUN);
    assign w_underflow = w_run && en && (count == '0);
    assign w_core_load = load || (start && !w_run);
    assign w_core_val  = load ? data_in : r_reload;

    mod12_down_core u_core (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_core_load),
        .i_load_val (w_core_val),
        .i_dec      (w_run && en),
        .i_wrap     (mode),
        .i_wrap_val (r_reload),
        .o_count    (count)
    );

    // Next state: load from anywhere enters RUN, start only from IDLE/DONE, one-shot underflow ends the run
    always_comb begin
        w_state_nxt = r_state;
        if (load)
            w_state_nxt = RUN;
        else if (!w_run)
            w_state_nxt = start ? RUN : r_state;
        else if (w_underflow && !mode)
            w_state_nxt = DONE;
    end

    // State, reload value and borrow pulse; borrow fires even when a load lands on the underflow edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_reload <= RELOAD_RST;
            r_borrow <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_borrow <= w_underflow;
            if (load)
                r_reload <= clamp12(data_in);
        end
    end

    assign borrow = r_borrow;
    assign busy   = (r_state == RUN);
    assign done   = (r_state == DONE);

endmodule

// File: tb/tb_mod12_down_timer.sv
// tb_mod12_down_timer: directed scenarios plus random traffic checked against a rule-level model
module tb_mod12_down_timer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load = 1'b0;
    logic [3:0] data_in = 4'd0;
    logic       en = 1'b0;
    logic       start = 1'b0;
    logic       mode = 1'b0;
    logic [3:0] count;
    logic       borrow;
    logic       busy;
    logic       done;

    int checks = 0;
    int failures = 0;

    int m_cnt = 0;
    int m_rel = 11;
    bit m_running = 0;
    bit m_finished = 0;
    bit m_borrow = 0;

    mod12_down_timer dut (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .data_in (data_in),
        .en      (en),
        .start   (start),
        .mode    (mode),
        .count   (count),
        .borrow  (borrow),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic model(input bit r, input bit l, input bit s, input bit e, input bit m, input int d);
        if (r) begin
            m_cnt = 0; m_rel = 11; m_running = 0; m_finished = 0; m_borrow = 0;
        end else begin
            m_borrow = m_running && e && (m_cnt == 0);
            if (l) begin
                m_cnt = (d > 11) ? 11 : d;
                m_rel = m_cnt;
                m_running = 1; m_finished = 0;
            end else if (!m_running && s) begin
                m_cnt = m_rel;
                m_running = 1; m_finished = 0;
            end else if (m_running && e) begin
                if (m_cnt != 0)
                    m_cnt = (m_cnt + 11) % 12;
                else if (m)
                    m_cnt = m_rel;
                else begin
                    m_running = 0; m_finished = 1;
                end
            end
        end
    endtask

    task automatic tick(input bit r, input bit l, input bit s, input bit e, input bit m, input int d);
        rst = r; load = l; start = s; en = e; mode = m; data_in = 4'(d);
        model(r, l, s, e, m, d);
        @(posedge clk);
        #1;
        chk("model_count", count, 4'(m_cnt));
        chk("model_borrow", {3'b0, borrow}, {3'b0, m_borrow});
        chk("model_busy", {3'b0, busy}, {3'b0, m_running});
        chk("model_done", {3'b0, done}, {3'b0, m_finished});
    endtask

    initial begin
        // Reset held for three cycles
        repeat (3) tick(1, 0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0, 0);
        chk("rst_count", count, 4'd0);
        chk("rst_busy", {3'b0, busy}, 4'd0);
        chk("rst_done", {3'b0, done}, 4'd0);
        chk("rst_borrow", {3'b0, borrow}, 4'd0);

        // One-shot run from 5
        tick(0, 1, 0, 1, 0, 5);
        chk("os_load", count, 4'd5);
        for (int i = 4; i >= 0; i--) begin
            tick(0, 0, 0, 1, 0, 0);
            chk("os_dec", count, 4'(i));
        end
        tick(0, 0, 0, 1, 0, 0);
        chk("os_borrow", {3'b0, borrow}, 4'd1);
        chk("os_done", {3'b0, done}, 4'd1);
        tick(0, 0, 0, 1, 0, 0);
        chk("os_borrow_end", {3'b0, borrow}, 4'd0);
        chk("os_hold", count, 4'd0);

        // Restart from DONE, then load on the underflow edge
        tick(0, 0, 1, 1, 0, 0);
        chk("start_count", count, 4'd5);
        chk("start_busy", {3'b0, busy}, 4'd1);
        repeat (5) tick(0, 0, 0, 1, 0, 0);
        chk("pre_uf", count, 4'd0);
        tick(0, 1, 0, 1, 0, 8);
        chk("uf_load_count", count, 4'd8);
        chk("uf_load_borrow", {3'b0, borrow}, 4'd1);
        chk("uf_load_busy", {3'b0, busy}, 4'd1);

        // Reset mid-run at count 4, then start uses the reset reload value
        repeat (4) tick(0, 0, 0, 1, 0, 0);
        chk("mid_count", count, 4'd4);
        tick(1, 0, 1, 1, 0, 0);
        chk("mid_rst_count", count, 4'd0);
        chk("mid_rst_busy", {3'b0, busy}, 4'd0);
        chk("mid_rst_borrow", {3'b0, borrow}, 4'd0);
        tick(0, 0, 1, 0, 0, 0);
        chk("rst_reload", count, 4'd11);

        // Periodic run with clamped load of 14
        tick(0, 1, 0, 1, 1, 14);
        chk("clamp", count, 4'd11);
        for (int k = 0; k < 2; k++) begin
            repeat (11) tick(0, 0, 0, 1, 1, 0);
            chk("per_zero", count, 4'd0);
            tick(0, 0, 0, 1, 1, 0);
            chk("per_reload", count, 4'd11);
            chk("per_borrow", {3'b0, borrow}, 4'd1);
            chk("per_busy", {3'b0, busy}, 4'd1);
        end

        // Enable gaps delay the underflow
        tick(0, 1, 0, 1, 0, 3);
        tick(0, 0, 0, 1, 0, 0);
        chk("en_dec", count, 4'd2);
        tick(0, 0, 1, 0, 0, 0);
        chk("en_hold1", count, 4'd2);
        tick(0, 0, 0, 0, 0, 0);
        chk("en_hold2", count, 4'd2);
        chk("en_hold_borrow", {3'b0, borrow}, 4'd0);
        repeat (2) tick(0, 0, 0, 1, 0, 0);
        chk("en_zero", count, 4'd0);
        tick(0, 0, 0, 1, 0, 0);
        chk("en_uf_borrow", {3'b0, borrow}, 4'd1);

        // Mode switched to periodic mid-run
        tick(0, 1, 0, 1, 0, 1);
        tick(0, 0, 0, 1, 1, 0);
        tick(0, 0, 0, 1, 1, 0);
        chk("mode_sw_count", count, 4'd1);
        chk("mode_sw_busy", {3'b0, busy}, 4'd1);

        // Random traffic
        for (int i = 0; i < 800; i++)
            tick($urandom_range(63) == 0, $urandom_range(9) == 0, $urandom_range(3) == 0,
                 $urandom_range(3) != 0, $urandom_range(7) < 5, $urandom_range(15));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mod12_down_timer.md
MOD12_DOWN_TIMER -- requirements
Module: mod12_down_timer

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high; ports are named clk and rst.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset; overrides every other input.
REQ-004 load  input  1  on a rising edge, loads data_in into count and into the reload register, and starts a run.
REQ-005 data_in  input  4  load value; legal range 0..11.
REQ-006 en  input  1  count enable; when 0 in RUN, count holds.
REQ-007 start  input  1  in IDLE or DONE, starts a run from the reload register.
REQ-008 mode  input  1  0 = one-shot, 1 = periodic auto-reload.
REQ-009 count  output  4  current counter value, always in 0..11.
REQ-010 borrow  output  1  registered one-cycle pulse on underflow.
REQ-011 busy  output  1  high while in RUN.
REQ-012 done  output  1  high while in DONE.

Function
REQ-013 The counter SHALL count down modulo 12 (11 -> 0), the reverse direction of the team's MOD12 up counter.
REQ-014 A load or start value above 11 SHALL be clamped to 11 before it is stored in count or in the reload register.
REQ-015 The FSM SHALL have exactly three states: IDLE, RUN and DONE; busy = (state == RUN) and done = (state == DONE), both combinational from state.
REQ-016 Input priority SHALL be rst > load > start > en.
REQ-017 load=1 in any state SHALL, on the same edge, set count and the reload register to clamp(data_in) and enter RUN.
REQ-018 start=1 with load=0 in IDLE or DONE SHALL set count to the reload register and enter RUN; start SHALL be ignored in RUN.
REQ-019 In RUN with en=1 and count>0, count SHALL decrement by 1 per edge.
REQ-020 In RUN with en=1 and count==0, borrow SHALL be 1 for exactly the next cycle.
REQ-021 At that count==0 edge with mode=1, count SHALL take the reload value and the FSM SHALL stay in RUN.
REQ-022 At that count==0 edge with mode=0, count SHALL stay 0 and the FSM SHALL enter DONE.
REQ-023 In RUN with en=0, count and state SHALL hold and borrow SHALL be 0.
REQ-024 In IDLE and DONE, count SHALL hold its value and borrow SHALL be 0.
REQ-025 load=1 on the same edge as an underflow SHALL win: the load value is applied, borrow still pulses, and the state is RUN.
REQ-026 A run loaded with value N SHALL reach underflow after N+1 enabled cycles; borrow is registered, so it appears one cycle after the count==0 edge.
REQ-027 A change of mode during RUN SHALL take effect at the next underflow.

Reset
REQ-028 rst=1 on an edge SHALL set count=0, reload register=11, state=IDLE and borrow=0, regardless of the other inputs.
REQ-029 rst asserted mid-run SHALL abort the run with no borrow pulse, and busy SHALL be 0 in the next cycle.

Structure
REQ-030 A shared package SHALL hold MOD12_MAX=11, the reload reset value of 11, a 4-bit count width constant, and the state enum {IDLE, RUN, DONE}.
REQ-031 The datapath SHALL be a sub-module named mod12_down_core (count register with load/decrement/wrap, plus clamp); the FSM, reload register and borrow flop SHALL live in the top module.
REQ-032 All outputs SHALL be driven from registers, or from state decode only.

Verification
REQ-033 rst=1 for 3 cycles, then rst=0 -> count=0, busy=0, done=0, borrow=0.
REQ-034 load with data_in=5, mode=0, en=1 -> count 5,4,3,2,1,0; one borrow pulse; then done=1 and count holds 0.
REQ-035 load with data_in=14, mode=1, en=1 -> count starts at 11; after 12 enabled cycles it underflows, borrow pulses, and count reloads 11 repeatedly.
REQ-036 data_in=3, en toggled 1,0,0,1 during RUN -> count holds at the en=0 cycles and underflow is delayed by 2 cycles.
REQ-037 From DONE with reload=5: start=1 gives count=5 and busy=1; then load data_in=8 on the underflow edge gives count=8, borrow=1, state RUN.
REQ-038 rst=1 while RUN at count=4 -> next cycle count=0, IDLE, no borrow; a subsequent start loads 11.
